// File: rtl/gf2_xform_pkg.sv
// Shared types and constants for the GF(2) matrix transform block:
// FSM states, the 8x8 power-on matrix for bank 0 and an index-width helper.
package gf2_xform_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Bank 0 rows 0..7 when W == 8; bit 7 of each row is column 0.
  localparam logic [7:0] DEFAULT_ROWS [8] = '{
    8'hA0, 8'hAC, 8'hD2, 8'h70, 8'hC6, 8'h52, 8'h0A, 8'hDD
  };

  // Width of an index into n items, never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2_matvec.sv
// Combinational W x W matrix-vector product over GF(2).
// Result bit W-1-i is the parity of row i masked by the input vector.
module gf2_matvec #(
  parameter int W = 8
) (
  input  logic [W-1:0][W-1:0] mat_i,
  input  logic [W-1:0]        vec_i,
  output logic [W-1:0]        prod_o
);

  always_comb begin
    prod_o = '0;
    for (int i = 0; i < W; i++) begin
      prod_o[W-1-i] = ^(mat_i[i] & vec_i);
    end
  end

endmodule

// File: rtl/gf2_matrix_xform.sv
// Two-stage GF(2) matrix transform with banked, row-writable matrices.
// Row writes wait for the pipeline to drain so no word sees a half-updated matrix.
module gf2_matrix_xform
  import gf2_xform_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int NBANK = 2,
  localparam int BW    = idxWidth(NBANK),
  localparam int RW    = idxWidth(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [BW-1:0] in_bank,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  input  logic          cfg_we,
  input  logic [BW-1:0] cfg_bank,
  input  logic [RW-1:0] cfg_row,
  input  logic [W-1:0]  cfg_data,
  output logic          cfg_ack
);

  typedef logic [W-1:0][W-1:0] matrix_t;

  matrix_t       mat_q [NBANK];
  state_e        state_q, state_d;
  logic          s1Valid_q, s1Valid_d;
  logic [W-1:0]  s1Data_q, s1Data_d;
  logic [BW-1:0] s1Bank_q, s1Bank_d;
  logic          s2Valid_q, s2Valid_d;
  logic [W-1:0]  s2Data_q, s2Data_d;

  logic          s2Free, s1CanTake, pipeEmpty, inFire;
  logic          inBankOk, cfgBankOk, cfgRowOk;
  logic [W-1:0]  product;

  function automatic logic [W-1:0] resetRow(input int b, input int i);
    logic [W-1:0] row;
    if (W == 8 && b == 0) row = W'(DEFAULT_ROWS[i[2:0]]);
    else                  row = W'(1) << (W - 1 - i);
    return row;
  endfunction

  assign s2Free    = !s2Valid_q || out_ready;
  assign s1CanTake = !s1Valid_q || s2Free;
  assign pipeEmpty = !s1Valid_q && !s2Valid_q;
  assign inFire    = in_valid && in_ready;
  assign inBankOk  = 32'(in_bank) < NBANK;
  assign cfgBankOk = 32'(cfg_bank) < NBANK;
  assign cfgRowOk  = 32'(cfg_row) < W;

  assign out_valid = s2Valid_q && !rst;
  assign out_data  = s2Data_q;

  gf2_matvec #(.W(W)) uMatvec (
    .mat_i  (mat_q[s1Bank_q]),
    .vec_i  (s1Data_q),
    .prod_o (product)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // A pending config write blocks new input immediately, even in the same cycle as in_valid.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cfg_ack  = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = !cfg_we && s1CanTake;
        if (cfg_we) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipeEmpty) state_d = cfg_we ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        cfg_ack = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      cfg_ack  = 1'b0;
    end
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s1Bank_d  = s1Bank_q;
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    if (s2Free) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) s2Data_d = product;
    end
    if (s1CanTake) begin
      s1Valid_d = inFire;
      if (inFire) begin
        s1Data_d = in_data;
        s1Bank_d = inBankOk ? in_bank : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Bank_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s1Bank_q  <= s1Bank_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int i = 0; i < W; i++) begin
          mat_q[b][i] <= resetRow(b, i);
        end
      end
    end else if (state_q == ST_LOAD && cfg_we && cfgBankOk && cfgRowOk) begin
      mat_q[cfg_bank][cfg_row] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_gf2_matrix_xform.sv
// Directed and randomized checks of gf2_matrix_xform against a parity-count
// model of the banked matrices, with a queue of expected results.
module tb_gf2_matrix_xform;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [0:0] in_bank;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       cfg_we;
  logic [0:0] cfg_bank;
  logic [2:0] cfg_row;
  logic [7:0] cfg_data;
  logic       cfg_ack;

  logic [7:0] modelMat [2][8];
  logic [7:0] expQ [$];
  int         compareCount = 0;
  int         failCount = 0;
  int         outCount = 0;
  int         ackCount = 0;
  bit         stallPending = 1'b0;
  bit         lastAccepted = 1'b0;

  always #5 clk = ~clk;

  gf2_matrix_xform #(.W(8), .NBANK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bank   (in_bank),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_bank  (cfg_bank),
    .cfg_row   (cfg_row),
    .cfg_data  (cfg_data),
    .cfg_ack   (cfg_ack)
  );

  function automatic logic [7:0] modelXform(input int bank, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = ($countones(modelMat[bank][i] & v) % 2) == 1;
    return r;
  endfunction

  task automatic resetModel();
    modelMat[0] = '{8'hA0, 8'hAC, 8'hD2, 8'h70, 8'hC6, 8'h52, 8'h0A, 8'hDD};
    for (int i = 0; i < 8; i++) modelMat[1][i] = 8'h80 >> i;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic b, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_bank   = b;
    out_ready = ordy;
  endtask

  // One clock: settle, score outputs and handshakes, then advance to the next negedge.
  task automatic tick();
    #1;
    if (stallPending) checkOutput("stall_valid", out_valid, 1);
    if (out_valid) begin
      if (expQ.size() == 0) checkOutput("unexpected_out", expQ.size(), 1);
      else begin
        checkOutput("out_data", out_data, expQ[0]);
        if (out_ready) begin
          void'(expQ.pop_front());
          outCount++;
        end
      end
    end
    stallPending = out_valid && !out_ready;
    lastAccepted = in_valid && in_ready;
    if (lastAccepted) expQ.push_back(modelXform(in_bank, in_data));
    if (cfg_ack) begin
      ackCount++;
      modelMat[cfg_bank][cfg_row] = cfg_data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    while (expQ.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    checkOutput("drain_done", expQ.size(), 0);
  endtask

  task automatic waitAck(input string tag, input int budget);
    int k;
    bit gotAck;
    k = 0;
    gotAck = 1'b0;
    while (!gotAck && k < budget) begin
      #1;
      checkOutput({tag, "_in_ready"}, in_ready, 0);
      gotAck = cfg_ack;
      tick();
      k++;
    end
    checkOutput({tag, "_ack_seen"}, gotAck, 1);
    cfg_we = 1'b0;
  endtask

  initial begin
    int acks, sent, cyc, outStart;
    logic [7:0] words [4];

    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_bank = '0;
    cfg_row  = '0;
    cfg_data = '0;
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
    resetModel();
    @(negedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_cfg_ack", cfg_ack, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    checkOutput("idle_in_ready", in_ready, 1);
    @(negedge clk);

    // Default bank 0, back-to-back words, two-cycle latency.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b1);
    tick();
    checkOutput("lat2_valid", out_valid, 1);
    checkOutput("b0_01", out_data, 8'h01);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("b0_80", out_data, 8'hE9);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("b0_FF", out_data, 8'h14);
    tick();
    checkOutput("b0_done", out_valid, 0);

    // Identity bank.
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("b1_valid", out_valid, 1);
    checkOutput("b1_5A", out_data, 8'h5A);
    tick();

    // Four words with a three-cycle downstream stall mid-stream.
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    outStart = outCount;
    sent = 0;
    cyc = 0;
    while ((sent < 4 || expQ.size() > 0) && cyc < 40) begin
      applyStimulus(sent < 4, (sent < 4) ? words[sent] : 8'h00, 1'b0, !(cyc >= 3 && cyc < 6));
      tick();
      if (lastAccepted) sent++;
      cyc++;
    end
    checkOutput("stall_delivered", outCount - outStart, 4);

    // Config write with two words in flight.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1);
    tick();
    cfg_we   = 1'b1;
    cfg_bank = 1'b1;
    cfg_row  = 3'd0;
    cfg_data = 8'hFF;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    acks = ackCount;
    waitAck("cfg_inflight", 20);
    checkOutput("cfg_ack_once", ackCount - acks, 1);
    tick();
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("cfg_b1_01", out_data, 8'h81);
    tick();
    checkOutput("cfg_no_reack", ackCount - acks, 1);

    // Config request and input in the same RUN cycle.
    drain(20);
    cfg_we   = 1'b1;
    cfg_bank = 1'b0;
    cfg_row  = 3'd3;
    cfg_data = 8'h0F;
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1);
    #1;
    checkOutput("sim_first_ready", in_ready, 0);
    waitAck("sim", 20);
    #1;
    checkOutput("sim_ready_after", in_ready, 1);
    tick();
    checkOutput("sim_accepted", lastAccepted, 1);
    drain(20);

    // Reset with two words in flight.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    expQ.delete();
    stallPending = 1'b0;
    resetModel();
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("midrst_no_stale", out_valid, 0);
    end
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("midrst_b1_restored", out_data, 8'h01);
    tick();

    // Random traffic with random backpressure.
    sent = 0;
    cyc = 0;
    while ((sent < 40 || expQ.size() > 0) && cyc < 600) begin
      applyStimulus((sent < 40) && ($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      tick();
      if (lastAccepted) sent++;
      cyc++;
    end
    checkOutput("rand_sent", sent, 40);
    checkOutput("rand_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/gf2_matrix_xform.md
GF2_MATRIX_XFORM -- requirements
Module: gf2_matrix_xform

Interface
REQ-001 Parameter W, default 8: datapath width and matrix dimension (W x W over GF(2)); legal range 2..32.
REQ-002 Parameter NBANK, default 2: number of independent matrix banks, each W rows of W bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 in_data  input  W  vector to transform.
REQ-008 in_bank  input  clog2(NBANK)  matrix bank applied to this word.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  W  transformed vector.
REQ-012 cfg_we  input  1  matrix-row write request; held high until cfg_ack.
REQ-013 cfg_bank  input  clog2(NBANK)  target bank.
REQ-014 cfg_row  input  clog2(W)  target row index.
REQ-015 cfg_data  input  W  row contents; bit W-1 is column 0.
REQ-016 cfg_ack  output  1  one-cycle pulse marking the cycle the row is written.

Function
REQ-017 For row word R_i (bank b), out_data[W-1-i] = XOR-reduce(R_i AND in_data), for i = 0..W-1.
REQ-018 A transfer occurs on in_valid&&in_ready (input) or out_valid&&out_ready (output).
REQ-019 Two-stage pipeline: S1 registers in_data/in_bank; S2 registers the GF(2) product; latency is exactly 2 cycles from input transfer to out_valid with no stall.
REQ-020 Full throughput of one word per cycle when out_ready is held high.
REQ-021 Stall: while out_valid&&!out_ready, out_data holds stable; S1 advances only into an empty or draining S2; no word is dropped or duplicated.
REQ-022 The bank is captured with the word in S1; the product uses the matrix contents present when the word leaves S1.
REQ-023 FSM states are RUN, DRAIN and LOAD.
REQ-024 RUN: in_ready = !cfg_we && S1 can advance; cfg_we high -> DRAIN.
REQ-025 DRAIN: in_ready = 0; when S1 and S2 are both empty -> LOAD.
REQ-026 LOAD (one cycle): write cfg_data to bank cfg_bank, row cfg_row; pulse cfg_ack; -> RUN.
REQ-027 If cfg_we and in_valid rise in the same RUN cycle, the configuration write wins: the input is not accepted.
REQ-028 If cfg_we drops before LOAD (protocol violation), no write occurs and the FSM returns to RUN once empty.
REQ-029 An out-of-range cfg_bank or cfg_row is ignored; cfg_ack still pulses.
REQ-030 An out-of-range in_bank selects bank 0.

Reset
REQ-031 On rst: FSM -> RUN; S1/S2 valid flags cleared; out_valid = 0; out_data = 0; cfg_ack = 0; in_ready = 0 during the reset cycle.
REQ-032 Reset matrix, bank 0 (W=8), rows 0..7 = A0, AC, D2, 70, C6, 52, 0A, DD (hex).
REQ-033 Every other bank, and bank 0 when W != 8, resets to identity: R_i = 1 << (W-1-i).
REQ-034 A reset mid-pipeline or mid-LOAD discards the in-flight words and the pending write.

Structure
REQ-035 A shared package gf2_xform_pkg holds the state enumeration, the 8x8 default-matrix constant and a clog2-style width helper.
REQ-036 One sub-module, gf2_matvec (combinational W x W GF(2) matrix-vector product), is instantiated in S2.

Verification
REQ-037 Reset, bank 0, in_data 01, 80, FF back-to-back, out_ready=1 -> out_data 01, E9, 14 on cycles +2, +3, +4.
REQ-038 Bank 1 (identity), in_data 5A -> out_data 5A after 2 cycles.
REQ-039 Stream of 4 words with out_ready low for 3 cycles mid-stream -> all 4 words delivered in order, out_data stable while stalled.
REQ-040 cfg_we writes bank 1 row 0 = FF while 2 words are in flight -> in_ready low until drained, cfg_ack pulses once; then in_data 01 on bank 1 -> out_data 81.
REQ-041 Simultaneous cfg_we and in_valid in RUN -> input not accepted that cycle; word accepted after cfg_ack.
REQ-042 rst asserted with 2 words in flight -> out_valid 0 the next cycle; no stale word emerges afterwards.
